toy_bpu_btq: RTL and testbench

- Parametrised branch-target queue between the BPU decode stage and the fetch filter.
- Accepts up to ENQ_W predictions per cycle on independent lanes. Lanes are compacted in lane order.
- Stores them in a power-of-two ring buffer and presents one entry per cycle through a registered output stage with valid/ready handshake.
- Provides registered credit-style backpressure, an occupancy count, a sticky overflow flag and a synchronous flush from the FE controller.

---
 rtl/toy_bpu_btq_pkg.sv | 9 +
 rtl/toy_bpu_btq_compact.sv | 24 ++
 rtl/toy_bpu_btq.sv | 139 +++++++++++++
 tb/tb_toy_bpu_btq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/toy_bpu_btq_pkg.sv
// Shared sizing for the BPU-to-fetch branch-target queue and its users.
// The queue stores payloads opaquely, so only widths and depths are defined here.
package toy_bpu_btq_pkg;

  localparam int BTQ_ENQ_W = 2;
  localparam int BTQ_DEPTH = 8;
  localparam int BPU_PLD_W = 64;

endpackage

// File: rtl/toy_bpu_btq_compact.sv
// Combinational lane compactor: per-lane slot offset (count of valid lanes below it) and popcount.
// Zero latency; no flow control of its own.
module toy_bpu_btq_compact
  import toy_bpu_btq_pkg::*;
#(
  parameter int ENQ_W = BTQ_ENQ_W,
  parameter int CNT_W = $clog2(ENQ_W + 1)
) (
  input  logic [ENQ_W-1:0]            mask,
  output logic [ENQ_W-1:0][CNT_W-1:0] offset,
  output logic [CNT_W-1:0]            count
);

  always_comb begin
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < ENQ_W; i++) begin
      offset[i] = acc;
      acc       = acc + CNT_W'(mask[i]);
    end
    count = acc;
  end

endmodule

// File: rtl/toy_bpu_btq.sv
// Multi-lane branch-target queue: ring buffer feeding a registered valid/ready output, 1-cycle bypass.
// enq_rdy is registered and only asserted when a full-width enqueue fits; lanes arriving while low are dropped.
module toy_bpu_btq
  import toy_bpu_btq_pkg::*;
#(
  parameter  int ENQ_W = BTQ_ENQ_W,
  parameter  int DEPTH = BTQ_DEPTH,
  parameter  int PLD_W = BPU_PLD_W,
  localparam int OCC_W = $clog2(DEPTH + 1) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ENQ_W-1:0]       enq_vld,
  input  logic [ENQ_W*PLD_W-1:0] enq_pld,
  output logic                   enq_rdy,
  output logic                   deq_vld,
  output logic [PLD_W-1:0]       deq_pld,
  input  logic                   deq_rdy,
  input  logic                   flush,
  output logic [OCC_W-1:0]       occupancy,
  output logic                   ovf_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int AW    = PTR_W + 1;
  localparam int CNT_W = $clog2(ENQ_W + 1);

  logic [AW-1:0]    rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [AW-1:0]    ring_cnt, ring_cnt_nxt, free_nxt;
  logic [PLD_W-1:0] ring [DEPTH];

  logic [ENQ_W-1:0]            take;
  logic [ENQ_W-1:0][CNT_W-1:0] offset;
  logic [ENQ_W-1:0][PTR_W-1:0] slot;
  logic [ENQ_W-1:0]            wr_en;
  logic [CNT_W-1:0]            n_in, n_wr;

  logic             ring_empty, deq_fire, load_ok, load_ring, bypass, ovf_evt;
  logic             deq_vld_nxt, enq_rdy_nxt;
  logic [PLD_W-1:0] bypass_pld, deq_pld_nxt;
  logic [OCC_W-1:0] occ_nxt;

  // A flush discards the same-cycle lanes outright, so they never reach the ring.
  assign take = enq_vld & {ENQ_W{enq_rdy & ~flush}};

  toy_bpu_btq_compact #(
    .ENQ_W(ENQ_W),
    .CNT_W(CNT_W)
  ) u_compact (
    .mask  (take),
    .offset(offset),
    .count (n_in)
  );

  assign ring_cnt   = wr_ptr - rd_ptr;
  assign ring_empty = (rd_ptr == wr_ptr);
  assign deq_fire   = deq_vld & deq_rdy;
  assign load_ok    = ~deq_vld | deq_fire;
  assign load_ring  = load_ok & ~ring_empty;
  assign bypass     = load_ok & ring_empty & (n_in != '0);
  assign n_wr       = n_in - CNT_W'(bypass);
  assign ovf_evt    = (|enq_vld) & ~enq_rdy & ~flush;

  // Lowest valid lane is the oldest, so iterate downwards and let it win.
  always_comb begin
    bypass_pld = '0;
    for (int i = ENQ_W - 1; i >= 0; i--) begin
      if (take[i]) bypass_pld = enq_pld[i*PLD_W +: PLD_W];
    end
  end

  always_comb begin
    for (int i = 0; i < ENQ_W; i++) begin
      wr_en[i] = take[i] & ~(bypass & (offset[i] == '0));
      slot[i]  = wr_ptr[PTR_W-1:0] + PTR_W'(offset[i]) - PTR_W'(bypass);
    end
  end

  always_comb begin
    rd_ptr_nxt   = rd_ptr + AW'(load_ring);
    wr_ptr_nxt   = wr_ptr + AW'(n_wr);
    ring_cnt_nxt = wr_ptr_nxt - rd_ptr_nxt;
    free_nxt     = AW'(DEPTH) - ring_cnt_nxt;
    enq_rdy_nxt  = (free_nxt >= AW'(ENQ_W));
    deq_vld_nxt  = load_ring | bypass | (deq_vld & ~deq_fire);
    deq_pld_nxt  = deq_pld;
    if (load_ring) begin
      deq_pld_nxt = ring[rd_ptr[PTR_W-1:0]];
    end else if (bypass) begin
      deq_pld_nxt = bypass_pld;
    end
    occ_nxt = OCC_W'(ring_cnt_nxt) + OCC_W'(deq_vld_nxt);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENQ_W; i++) begin
      if (wr_en[i]) ring[slot[i]] <= enq_pld[i*PLD_W +: PLD_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      deq_vld   <= 1'b0;
      deq_pld   <= '0;
      enq_rdy   <= 1'b1;
      occupancy <= '0;
      ovf_err   <= 1'b0;
    end else begin
      if (ovf_evt) ovf_err <= 1'b1;
      if (flush) begin
        // deq_pld deliberately keeps its stale value.
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        deq_vld   <= 1'b0;
        enq_rdy   <= 1'b1;
        occupancy <= '0;
      end else begin
        rd_ptr    <= rd_ptr_nxt;
        wr_ptr    <= wr_ptr_nxt;
        deq_vld   <= deq_vld_nxt;
        deq_pld   <= deq_pld_nxt;
        enq_rdy   <= enq_rdy_nxt;
        occupancy <= occ_nxt;
      end
    end
  end

  a_pld_stable: assert property (@(posedge clk) disable iff (!rst_n)
    deq_vld && !deq_rdy |=> $stable(deq_pld));

  a_occ_max: assert property (@(posedge clk) disable iff (!rst_n)
    occupancy <= OCC_W'(DEPTH + 1));

  a_no_overwrite: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, ring_cnt} + (AW + 1)'(n_wr)) <= (AW + 1)'(DEPTH));

endmodule

// File: tb/tb_toy_bpu_btq.sv
// Bench for toy_bpu_btq: directed vector table, async reset sequence, then randomized traffic vs a queue model.
module tb_toy_bpu_btq;

  localparam int ENQ_W = 2;
  localparam int DEPTH = 8;
  localparam int PLD_W = 64;
  localparam int OCC_W = $clog2(DEPTH + 1) + 1;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [ENQ_W-1:0]       enq_vld;
  logic [ENQ_W*PLD_W-1:0] enq_pld;
  logic                   enq_rdy;
  logic                   deq_vld;
  logic [PLD_W-1:0]       deq_pld;
  logic                   deq_rdy;
  logic                   flush;
  logic [OCC_W-1:0]       occupancy;
  logic                   ovf_err;

  toy_bpu_btq #(.ENQ_W(ENQ_W), .DEPTH(DEPTH), .PLD_W(PLD_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enq_vld  (enq_vld),
    .enq_pld  (enq_pld),
    .enq_rdy  (enq_rdy),
    .deq_vld  (deq_vld),
    .deq_pld  (deq_pld),
    .deq_rdy  (deq_rdy),
    .flush    (flush),
    .occupancy(occupancy),
    .ovf_err  (ovf_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0] vld;
    logic [7:0] p0;
    logic [7:0] p1;
    logic       rdy;
    logic       fl;
    logic       e_vld;
    logic [7:0] e_pld;
    logic [4:0] e_occ;
    logic       e_rdy;
    logic       e_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] v, input logic [7:0] p0, input logic [7:0] p1,
                     input logic r, input logic f, input logic ev, input logic [7:0] ep,
                     input logic [4:0] eo, input logic er, input logic eovf);
    vec_t t;
    t.vld = v; t.p0 = p0; t.p1 = p1; t.rdy = r; t.fl = f;
    t.e_vld = ev; t.e_pld = ep; t.e_occ = eo; t.e_rdy = er; t.e_ovf = eovf;
    tbl.push_back(t);
  endtask

  // Behavioural model: every held entry (output register + ring) as one FIFO.
  logic [63:0] mq[$];
  logic        m_rdy;
  logic        m_ovf;

  task automatic model_step(input logic [1:0] v, input logic [63:0] p0, input logic [63:0] p1,
                            input logic r, input logic f);
    int ring;
    if (f) begin
      mq.delete();
      m_rdy = 1'b1;
    end else begin
      if (mq.size() > 0 && r) void'(mq.pop_front());
      if (m_rdy) begin
        if (v[0]) mq.push_back(p0);
        if (v[1]) mq.push_back(p1);
      end else if (v != 2'b00) begin
        m_ovf = 1'b1;
      end
      ring  = (mq.size() > 0) ? mq.size() - 1 : 0;
      m_rdy = (DEPTH - ring) >= ENQ_W;
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_vld"}, 64'(deq_vld), 64'(mq.size() > 0));
    if (mq.size() > 0) chk({tag, "_pld"}, deq_pld, mq[0]);
    chk({tag, "_occ"}, 64'(occupancy), 64'(mq.size()));
    chk({tag, "_rdy"}, 64'(enq_rdy), 64'(m_rdy));
    chk({tag, "_ovf"}, 64'(ovf_err), 64'(m_ovf));
  endtask

  initial begin
    logic [63:0] seq;
    rst_n   = 1'b0;
    enq_vld = '0;
    enq_pld = '0;
    deq_rdy = 1'b0;
    flush   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_deq_vld", 64'(deq_vld), 64'd0);
    chk("rst_deq_pld", deq_pld, 64'd0);
    chk("rst_enq_rdy", 64'(enq_rdy), 64'd1);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_ovf", 64'(ovf_err), 64'd0);

    //   vld    p0     p1     rdy   fl    e_vld e_pld  occ  e_rdy e_ovf
    add(2'b01, 8'hA1, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA1, 5'd1, 1'b1, 1'b0);
    add(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA1, 5'd0, 1'b1, 1'b0);
    add(2'b10, 8'hEE, 8'hB2, 1'b0, 1'b0, 1'b1, 8'hB2, 5'd1, 1'b1, 1'b0);
    add(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'hB2, 5'd0, 1'b1, 1'b0);
    add(2'b11, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 8'h01, 5'd2, 1'b1, 1'b0);
    add(2'b11, 8'h03, 8'h04, 1'b0, 1'b0, 1'b1, 8'h01, 5'd4, 1'b1, 1'b0);
    add(2'b11, 8'h05, 8'h06, 1'b0, 1'b0, 1'b1, 8'h01, 5'd6, 1'b1, 1'b0);
    add(2'b11, 8'h07, 8'h08, 1'b0, 1'b0, 1'b1, 8'h01, 5'd8, 1'b0, 1'b0);
    add(2'b01, 8'h99, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 5'd8, 1'b0, 1'b1);
    for (int k = 2; k <= 8; k++)
      add(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'(k), 5'(9 - k), 1'b1, 1'b1);
    add(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h08, 5'd0, 1'b1, 1'b1);
    add(2'b01, 8'h41, 8'h00, 1'b1, 1'b0, 1'b1, 8'h41, 5'd1, 1'b1, 1'b1);
    add(2'b01, 8'h42, 8'h00, 1'b1, 1'b0, 1'b1, 8'h42, 5'd1, 1'b1, 1'b1);
    add(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h42, 5'd0, 1'b1, 1'b1);
    add(2'b11, 8'h11, 8'h12, 1'b0, 1'b0, 1'b1, 8'h11, 5'd2, 1'b1, 1'b1);
    add(2'b11, 8'h13, 8'h14, 1'b0, 1'b0, 1'b1, 8'h11, 5'd4, 1'b1, 1'b1);
    add(2'b01, 8'h15, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 5'd5, 1'b1, 1'b1);
    add(2'b11, 8'h21, 8'h22, 1'b1, 1'b1, 1'b0, 8'h11, 5'd0, 1'b1, 1'b1);
    add(2'b01, 8'h31, 8'h00, 1'b0, 1'b0, 1'b1, 8'h31, 5'd1, 1'b1, 1'b1);
    add(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h31, 5'd0, 1'b1, 1'b1);

    for (int i = 0; i < tbl.size(); i++) begin
      enq_vld = tbl[i].vld;
      enq_pld = {64'(tbl[i].p1), 64'(tbl[i].p0)};
      deq_rdy = tbl[i].rdy;
      flush   = tbl[i].fl;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_vld", i), 64'(deq_vld), 64'(tbl[i].e_vld));
      chk($sformatf("v%0d_pld", i), deq_pld, 64'(tbl[i].e_pld));
      chk($sformatf("v%0d_occ", i), 64'(occupancy), 64'(tbl[i].e_occ));
      chk($sformatf("v%0d_rdy", i), 64'(enq_rdy), 64'(tbl[i].e_rdy));
      chk($sformatf("v%0d_ovf", i), 64'(ovf_err), 64'(tbl[i].e_ovf));
    end

    // Async reset in the middle of a cycle with a partly filled queue clears everything, including ovf_err.
    enq_vld = 2'b11;
    enq_pld = {64'h52, 64'h51};
    deq_rdy = 1'b0;
    flush   = 1'b0;
    @(posedge clk);
    #1 enq_vld = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_deq_vld", 64'(deq_vld), 64'd0);
    chk("arst_deq_pld", deq_pld, 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_enq_rdy", 64'(enq_rdy), 64'd1);
    chk("arst_ovf", 64'(ovf_err), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    mq.delete();
    m_rdy = 1'b1;
    m_ovf = 1'b0;
    seq   = 64'hC0DE_0000_0000_0000;
    for (int c = 0; c < 1000; c++) begin
      int r;
      logic [1:0] v;
      r = $urandom_range(0, 7);
      v = (r < 5) ? 2'b11 : 2'(r - 5);
      if (!m_rdy) v = 2'b00;
      enq_vld = v;
      enq_pld = {seq + 64'd1, seq};
      deq_rdy = 1'($urandom_range(0, 1));
      flush   = ($urandom_range(0, 99) == 0);
      @(posedge clk);
      model_step(v, seq, seq + 64'd1, deq_rdy, flush);
      seq = seq + 64'd2;
      #1;
      chk_model("rnd");
    end

    enq_vld = '0;
    flush   = 1'b0;
    deq_rdy = 1'b1;
    for (int c = 0; c < DEPTH + 2; c++) begin
      @(posedge clk);
      model_step(2'b00, 64'd0, 64'd0, 1'b1, 1'b0);
      #1;
      chk_model("drain");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
